// File: rtl/edge_event_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : edge_pkg
//  Description : Shared edge-mode encoding and width helpers for the
//                multi-channel edge event unit.
//  Revision    : 1.0  initial release
// ============================================================================
package edge_pkg;

   // Per-channel edge selection, two bits per channel in the mode bus.
   typedef enum logic [1:0] {
      EDGE_OFF  = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_mode_e;

   // Filter counter must hold values 0..FILT_CYC.
   function automatic int fcnt_width(input int filt_cyc);
      return $clog2(filt_cyc + 1);
   endfunction

   // Counter read-select width; never narrower than one bit.
   function automatic int sel_width(input int ch);
      return (ch > 1) ? $clog2(ch) : 1;
   endfunction

   function automatic logic rise_enabled(input logic [1:0] mode);
      return (mode == EDGE_RISE) || (mode == EDGE_BOTH);
   endfunction

   function automatic logic fall_enabled(input logic [1:0] mode);
      return (mode == EDGE_FALL) || (mode == EDGE_BOTH);
   endfunction

endpackage
`default_nettype wire

// File: rtl/edge_event_unit_if.sv
`default_nettype none
// ============================================================================
//  Interface   : edge_event_unit_if
//  Description : Pad-side inputs, CSR-side controls and event outputs of the
//                edge event unit. master = CSR/control side, slave = unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface edge_event_unit_if
   import edge_pkg::*;
#(
   parameter int CH    = 8,
   parameter int CNT_W = 16
);
   localparam int SEL_W = sel_width(CH);

   logic [CH-1:0]    din;
   logic [2*CH-1:0]  mode;
   logic [CH-1:0]    level;
   logic [CH-1:0]    rise;
   logic [CH-1:0]    fall;
   logic [CH-1:0]    evt_flag;
   logic [CH-1:0]    evt_clr;
   logic             irq;
   logic [SEL_W-1:0] cnt_sel;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_clr;

   modport master (
      output din, mode, evt_clr, cnt_sel, cnt_clr,
      input  level, rise, fall, evt_flag, irq, cnt_val
   );

   modport slave (
      input  din, mode, evt_clr, cnt_sel, cnt_clr,
      output level, rise, fall, evt_flag, irq, cnt_val
   );

endinterface
`default_nettype wire

// File: rtl/edge_event_unit_filt.sv
`default_nettype none
// ============================================================================
//  Module      : edge_filt_ch
//  Description : One input channel: synchroniser chain, glitch filter and
//                registered level / rise / fall outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module edge_filt_ch
   import edge_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYC    = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);
   localparam int              FCNT_W    = fcnt_width(FILT_CYC);
   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILT_CYC - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   w_s;
   logic                   level_q, level_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic [FCNT_W-1:0]      fcnt_q, fcnt_d;

   assign w_s = sync_q[SYNC_STAGES-1];

   // Synchroniser: raw pad goes straight into the first flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      end
   end

   // Filter: a new level is accepted only after FILT_CYC consecutive mismatches.
   always_comb begin
      level_d = level_q;
      fcnt_d  = '0;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (w_s != level_q) begin
         if (fcnt_q == FCNT_LAST) begin
            level_d = ~level_q;
            rise_d  = ~level_q;
            fall_d  = level_q;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
   end

   // Level and edge pulses are registered together so they line up.
   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         fcnt_q  <= '0;
      end else begin
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule
`default_nettype wire

// File: rtl/edge_event_unit.sv
`default_nettype none
// ============================================================================
//  Module      : edge_event_unit
//  Description : Multi-channel filtered edge detector with per-channel mode
//                qualification, sticky W1C flags, saturating edge counters
//                and a combined interrupt.
//  Revision    : 1.0  initial release
// ============================================================================
module edge_event_unit
   import edge_pkg::*;
#(
   parameter int CH          = 8,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYC    = 4,
   parameter int CNT_W       = 16
) (
   input  logic           clk,
   input  logic           rst,
   edge_event_unit_if.slave bus
);
   localparam int               SEL_W   = sel_width(CH);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CH-1:0]    w_level;
   logic [CH-1:0]    w_rise;
   logic [CH-1:0]    w_fall;
   logic [CH-1:0]    w_qual;
   logic [CH-1:0]    evt_flag_q, evt_flag_d;
   logic             irq_q;
   logic [CNT_W-1:0] cnt_q [CH];
   logic [CNT_W-1:0] cnt_d [CH];
   logic [CNT_W-1:0] w_cnt_val;

   generate
      for (genvar c = 0; c < CH; c++) begin : g_ch
         edge_filt_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYC    (FILT_CYC)
         ) u_filt (
            .clk     (clk),
            .rst     (rst),
            .din_i   (bus.din[c]),
            .level_o (w_level[c]),
            .rise_o  (w_rise[c]),
            .fall_o  (w_fall[c])
         );
      end
   endgenerate

   // Qualify raw edges with the mode currently applied; nothing is replayed.
   always_comb begin
      w_qual = '0;
      for (int c = 0; c < CH; c++) begin
         w_qual[c] = (w_rise[c] && rise_enabled(bus.mode[2*c +: 2])) ||
                     (w_fall[c] && fall_enabled(bus.mode[2*c +: 2]));
      end
   end

   // Next flag / counter values; a same-cycle event beats a clear.
   always_comb begin
      evt_flag_d = (evt_flag_q & ~bus.evt_clr) | w_qual;
      for (int c = 0; c < CH; c++) begin
         cnt_d[c] = cnt_q[c];
         if (bus.cnt_clr) begin
            cnt_d[c] = CNT_W'(w_qual[c]);
         end else if (w_qual[c] && (cnt_q[c] != CNT_MAX)) begin
            cnt_d[c] = cnt_q[c] + 1'b1;
         end
      end
   end

   // Flags, irq and counters; irq follows the next flag state so it tracks flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         evt_flag_q <= '0;
         irq_q      <= 1'b0;
         for (int c = 0; c < CH; c++) begin
            cnt_q[c] <= '0;
         end
      end else begin
         evt_flag_q <= evt_flag_d;
         irq_q      <= |evt_flag_d;
         for (int c = 0; c < CH; c++) begin
            cnt_q[c] <= cnt_d[c];
         end
      end
   end

   // Counter read mux; unmatched selects read as zero.
   always_comb begin
      w_cnt_val = '0;
      for (int c = 0; c < CH; c++) begin
         if (bus.cnt_sel == SEL_W'(c)) begin
            w_cnt_val = cnt_q[c];
         end
      end
   end

   assign bus.level    = w_level;
   assign bus.rise     = w_rise;
   assign bus.fall     = w_fall;
   assign bus.evt_flag = evt_flag_q;
   assign bus.irq      = irq_q;
   assign bus.cnt_val  = w_cnt_val;

endmodule
`default_nettype wire
